bip_control_unit: RTL and testbench



---
 rtl/bip_control_unit.sv | 163 ++++++++++++++++
 tb/tb_bip_control_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bip_control_unit.sv
// Control unit for the BIP accumulator processor: PC, FETCH/EXEC/HALT sequencing and decode.
// Optional CYCLE_COUNT_EN adds a saturating 32-bit cycle_count output.
module bip_control_unit #(
  parameter int unsigned         PC_WIDTH      = 11,
  parameter int unsigned         OPCODE_WIDTH  = 5,
  parameter int unsigned         OPERAND_WIDTH = 11,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR  = '0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] instr_data,
  output logic [PC_WIDTH-1:0]                   address_output,
  output logic [OPERAND_WIDTH-1:0]              operand,
  output logic [1:0]                            sel_a,
  output logic                                  sel_b,
  output logic                                  op,
  output logic                                  wr_acc,
  output logic                                  rd_ram,
  output logic                                  wr_ram,
  output logic                                  halted
`ifdef CYCLE_COUNT_EN
  ,
  output logic [31:0]                           cycle_count
`endif
);

  localparam int unsigned InstrWidth = OPCODE_WIDTH + OPERAND_WIDTH;

  localparam logic [1:0] StFetch = 2'd0;
  localparam logic [1:0] StExec  = 2'd1;
  localparam logic [1:0] StHalt  = 2'd2;

  localparam logic [4:0] OpHlt  = 5'b00000;
  localparam logic [4:0] OpSto  = 5'b00001;
  localparam logic [4:0] OpLd   = 5'b00010;
  localparam logic [4:0] OpLdi  = 5'b00011;
  localparam logic [4:0] OpAdd  = 5'b00100;
  localparam logic [4:0] OpAddi = 5'b00101;
  localparam logic [4:0] OpSub  = 5'b00110;
  localparam logic [4:0] OpSubi = 5'b00111;

  logic [1:0]              state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [4:0]              opcode_lo;
  logic                    upper_ok;
  logic                    is_hlt;
  logic                    active;

  assign opcode    = instr_data[InstrWidth-1 -: OPCODE_WIDTH];
  assign opcode_lo = opcode[4:0];

  // Wide opcodes only alias the base set when their extra bits are clear.
  if (OPCODE_WIDTH > 5) begin : g_upper
    assign upper_ok = ~|opcode[OPCODE_WIDTH-1:5];
  end else begin : g_no_upper
    assign upper_ok = 1'b1;
  end

  assign is_hlt = upper_ok && (opcode_lo == OpHlt);
  assign active = (state_q == StExec) && enable && !reset;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      StFetch: begin
        if (enable) state_d = StExec;
      end
      StExec: begin
        if (enable) begin
          if (is_hlt) begin
            state_d = StHalt;
          end else begin
            state_d = StFetch;
            pc_d    = pc_q + 1'b1;
          end
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    sel_a  = 2'b00;
    sel_b  = 1'b0;
    op     = 1'b0;
    wr_acc = 1'b0;
    rd_ram = 1'b0;
    wr_ram = 1'b0;
    if (active && upper_ok) begin
      case (opcode_lo)
        OpSto: wr_ram = 1'b1;
        OpLd: begin
          rd_ram = 1'b1;
          wr_acc = 1'b1;
        end
        OpLdi: begin
          sel_a  = 2'b01;
          wr_acc = 1'b1;
        end
        OpAdd: begin
          rd_ram = 1'b1;
          sel_a  = 2'b10;
          wr_acc = 1'b1;
        end
        OpAddi: begin
          sel_a  = 2'b10;
          sel_b  = 1'b1;
          wr_acc = 1'b1;
        end
        OpSub: begin
          rd_ram = 1'b1;
          sel_a  = 2'b10;
          op     = 1'b1;
          wr_acc = 1'b1;
        end
        OpSubi: begin
          sel_a  = 2'b10;
          sel_b  = 1'b1;
          op     = 1'b1;
          wr_acc = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign address_output = pc_q;
  assign operand        = (state_q == StExec) ? instr_data[OPERAND_WIDTH-1:0] : '0;
  assign halted         = (state_q == StHalt);

`ifdef CYCLE_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (enable && (state_q != StHalt) && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cycle_count = cnt_q;
`else
  // No cycle counter in this build.
`endif

endmodule

// File: tb/tb_bip_control_unit.sv
// Directed self-checking bench for bip_control_unit (default build plus a 0x7FF reset-vector copy).
module tb_bip_control_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable;
  logic [15:0] instr;
  logic [10:0] addr, operand;
  logic [1:0]  sel_a;
  logic        sel_b, op, wr_acc, rd_ram, wr_ram, halted;

  logic        reset_w, enable_w;
  logic [15:0] instr_w;
  logic [10:0] addr_w, operand_w;
  logic [1:0]  sel_a_w;
  logic        sel_b_w, op_w, wr_acc_w, rd_ram_w, wr_ram_w, halted_w;

  logic [6:0] strb, strb_w;
  assign strb   = {sel_a, sel_b, op, wr_acc, rd_ram, wr_ram};
  assign strb_w = {sel_a_w, sel_b_w, op_w, wr_acc_w, rd_ram_w, wr_ram_w};

  bip_control_unit dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .instr_data    (instr),
    .address_output(addr),
    .operand       (operand),
    .sel_a         (sel_a),
    .sel_b         (sel_b),
    .op            (op),
    .wr_acc        (wr_acc),
    .rd_ram        (rd_ram),
    .wr_ram        (wr_ram),
    .halted        (halted)
  );

  bip_control_unit #(.RESET_VECTOR(11'h7FF)) dut_w (
    .clk           (clk),
    .reset         (reset_w),
    .enable        (enable_w),
    .instr_data    (instr_w),
    .address_output(addr_w),
    .operand       (operand_w),
    .sel_a         (sel_a_w),
    .sel_b         (sel_b_w),
    .op            (op_w),
    .wr_acc        (wr_acc_w),
    .rd_ram        (rd_ram_w),
    .wr_ram        (wr_ram_w),
    .halted        (halted_w)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; instr = 16'h0000;
    reset_w = 1'b1; enable_w = 1'b1; instr_w = 16'h0000;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_strb", 32'(strb), 32'h0);
    chk("rst_operand", 32'(operand), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);

    // LDI 5
    tick(); instr = 16'h1805; #1;
    chk("ldi_strb", 32'(strb), 32'b01_0_0_1_0_0);
    chk("ldi_operand", 32'(operand), 32'h5);
    chk("ldi_addr", 32'(addr), 32'h0);
    tick(); #1;
    chk("pc1", 32'(addr), 32'h1);
    chk("fetch_strb", 32'(strb), 32'h0);

    // ADD 3
    tick(); instr = 16'h2003; #1;
    chk("add_strb", 32'(strb), 32'b10_0_0_1_1_0);
    chk("add_operand", 32'(operand), 32'h3);
    tick(); #1;
    chk("pc2", 32'(addr), 32'h2);

    // SUBI 2
    tick(); instr = 16'h3802; #1;
    chk("subi_strb", 32'(strb), 32'b10_1_1_1_0_0);
    tick(); #1;
    chk("pc3", 32'(addr), 32'h3);

    // STO 7
    tick(); instr = 16'h0807; #1;
    chk("sto_strb", 32'(strb), 32'b00_0_0_0_0_1);
    tick(); #1;
    chk("pc4", 32'(addr), 32'h4);

    // HLT at 4
    tick(); instr = 16'h0000; #1;
    chk("hlt_exec_strb", 32'(strb), 32'h0);
    chk("hlt_exec_halted", 32'(halted), 32'h0);
    tick(); #1;
    chk("halted", 32'(halted), 32'h1);
    chk("halt_addr", 32'(addr), 32'h4);
    for (int i = 0; i < 20; i++) begin
      enable = i[0];
      instr  = 16'h1805;
      #1;
      chk("halt_hold_addr", 32'(addr), 32'h4);
      chk("halt_hold_strb", 32'(strb), 32'h0);
      chk("halt_hold_flag", 32'(halted), 32'h1);
      tick();
    end
    enable = 1'b1;

    // Only reset leaves HALT
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("unhalt_addr", 32'(addr), 32'h0);
    chk("unhalt_flag", 32'(halted), 32'h0);

    // FETCH holds while disabled
    enable = 1'b0; instr = 16'h1009;
    tick(); #1;
    chk("fetch_frz_addr", 32'(addr), 32'h0);
    chk("fetch_frz_strb", 32'(strb), 32'h0);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("exec_frz_strb", 32'(strb), 32'h0);
      chk("exec_frz_addr", 32'(addr), 32'h0);
      tick();
    end
    enable = 1'b1; #1;
    chk("ld_strb", 32'(strb), 32'b00_0_0_1_1_0);
    chk("ld_operand", 32'(operand), 32'h9);
    tick(); #1;
    chk("ld_pc", 32'(addr), 32'h1);

    // Reset in EXEC suppresses strobes in the same cycle
    tick(); instr = 16'h1805; reset = 1'b1; #1;
    chk("rst_exec_strb", 32'(strb), 32'h0);
    tick(); reset = 1'b0; #1;
    chk("rst_exec_addr", 32'(addr), 32'h0);
    chk("rst_exec_after_strb", 32'(strb), 32'h0);

    // Reset vector 0x7FF and PC wrap through a NOP
    reset_w = 1'b0; #1;
    chk("w_rst_addr", 32'(addr_w), 32'h7FF);
    chk("w_rst_strb", 32'(strb_w), 32'h0);
    tick(); instr_w = 16'hF800; #1;
    chk("w_nop_strb", 32'(strb_w), 32'h0);
    tick(); #1;
    chk("w_wrap_addr", 32'(addr_w), 32'h0);
    tick(); instr_w = 16'h1805; reset_w = 1'b1; #1;
    chk("w_rst_exec_strb", 32'(strb_w), 32'h0);
    tick(); reset_w = 1'b0; #1;
    chk("w_rst_exec_addr", 32'(addr_w), 32'h7FF);
    chk("w_rst_exec_after_strb", 32'(strb_w), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
